// File: rtl/regfile_pkg.sv
// Shared register-file constants and types: architectural register indices
// and the default index/word types for the 32 x 32 configuration.
package regfile_pkg;

    localparam int REG_ZERO = 0;
    localparam int REG_RA   = 1;
    localparam int REG_T0   = 5;
    localparam int REG_A0   = 10;

    localparam int DEF_ADDRESS_WIDTH = 5;
    localparam int DEF_DATA_WIDTH    = 32;

    typedef logic [DEF_ADDRESS_WIDTH-1:0] reg_idx_t;
    typedef logic [DEF_DATA_WIDTH-1:0]    word_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits tracking issued-but-not-written-back producers,
// plus one busy lookup per read port.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int READ_PORTS    = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                pend_set,
    input  logic [ADDRESS_WIDTH-1:0]            pend_addr,
    input  logic                                clr_en,
    input  logic [ADDRESS_WIDTH-1:0]            clr_addr,
    input  logic [READ_PORTS*ADDRESS_WIDTH-1:0] rd_addr,
    output logic [READ_PORTS-1:0]               rd_busy
);

    localparam int DEPTH = 1 << ADDRESS_WIDTH;

    logic [DEPTH-1:0] pending;
    logic [DEPTH-1:0] pending_next;

    // Clear is applied first so a same-cycle set (newer producer) wins.
    always_comb begin
        pending_next = pending;
        if (clr_en) begin
            pending_next[clr_addr] = 1'b0;
        end
        if (pend_set) begin
            pending_next[pend_addr] = 1'b1;
        end
        pending_next[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_busy
        logic [ADDRESS_WIDTH-1:0] addr;
        logic                     resolving;
        assign addr      = rd_addr[p*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        // The writeback landing this cycle satisfies the operand immediately.
        assign resolving = clr_en && (clr_addr == addr) && (addr != '0);
        assign rd_busy[p] = pending[addr] && !resolving;
    end

endmodule

// File: rtl/regfile_fwd.sv
// Decode-stage register file: combinational read ports with write-through
// bypass, trigger-forced t0, pending scoreboard and raw a0/ra exports.
module regfile_fwd
    import regfile_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int READ_PORTS    = 2,
    parameter int TRIGGER_REG   = REG_T0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [READ_PORTS*ADDRESS_WIDTH-1:0] rd_addr,
    output logic [READ_PORTS*DATA_WIDTH-1:0]    rd_data,
    output logic [READ_PORTS-1:0]               rd_busy,
    input  logic                                we,
    input  logic [ADDRESS_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0]               wr_data,
    input  logic                                pend_set,
    input  logic [ADDRESS_WIDTH-1:0]            pend_addr,
    input  logic                                trigger,
    output logic [DATA_WIDTH-1:0]               a0,
    output logic [DATA_WIDTH-1:0]               ra
);

    localparam int                       DEPTH    = 1 << ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] TRIG_IDX = ADDRESS_WIDTH'(TRIGGER_REG);
    localparam logic [ADDRESS_WIDTH-1:0] A0_IDX   = ADDRESS_WIDTH'(REG_A0);
    localparam logic [ADDRESS_WIDTH-1:0] RA_IDX   = ADDRESS_WIDTH'(REG_RA);
    localparam logic [DATA_WIDTH-1:0]    ONE      = DATA_WIDTH'(1);

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic                  wr_live;

    assign wr_live = we && (wr_addr != '0);

    // Trigger is applied after the write so it overrides a write to t0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wr_live) begin
                regs[wr_addr] <= wr_data;
            end
            if (trigger) begin
                regs[TRIG_IDX] <= ONE;
            end
        end
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]    data;
        assign addr = rd_addr[p*ADDRESS_WIDTH +: ADDRESS_WIDTH];

        always_comb begin
            if (addr == '0) begin
                data = '0;
            end else if (trigger && (addr == TRIG_IDX)) begin
                data = ONE;
            end else if (we && (wr_addr == addr)) begin
                data = wr_data;
            end else begin
                data = regs[addr];
            end
        end

        assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = data;
    end

    regfile_scoreboard #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .READ_PORTS    (READ_PORTS)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .pend_set  (pend_set),
        .pend_addr (pend_addr),
        .clr_en    (wr_live),
        .clr_addr  (wr_addr),
        .rd_addr   (rd_addr),
        .rd_busy   (rd_busy)
    );

    assign a0 = regs[A0_IDX];
    assign ra = regs[RA_IDX];

endmodule
